// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one decoded memory request becomes one word-aligned
// bus transaction, returning extended load data or a fault cause.
//
// state | meaning
// IDLE  | ready for a request; decode faults go straight to RESP
// BUS   | bus transaction outstanding, timeout counting
// RESP  | response held until the consumer accepts it
module rv32i_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_mask,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_cause
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] CAUSE_OK        = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'd2;
  localparam logic [1:0] CAUSE_BUS_FAULT = 2'd3;

  // Counter only needs to reach TIMEOUT_CYCLES-1; the last idle cycle ends BUS.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] to_cnt;
  logic [1:0]    lat_off;
  logic [2:0]    lat_f3;

  logic        is_load_in;
  logic        is_store_in;
  logic        illegal_in;
  logic        misalign_in;
  logic [3:0]  mask_in;
  logic [31:0] wdata_in;
  logic [31:0] lane;
  logic [31:0] load_data;

  always_comb begin
    is_load_in  = (req_op == OP_LOAD);
    is_store_in = (req_op == OP_STORE);

    illegal_in = 1'b0;
    if (!is_load_in && !is_store_in)
      illegal_in = 1'b1;
    else if (is_load_in && (req_f3 == 3'b011 || req_f3 == 3'b110 || req_f3 == 3'b111))
      illegal_in = 1'b1;
    else if (is_store_in && req_f3 >= 3'b011)
      illegal_in = 1'b1;

    // f3[1:0] encodes access size for both loads and stores.
    misalign_in = 1'b0;
    case (req_f3[1:0])
      2'b01:   misalign_in = req_addr[0];
      2'b10:   misalign_in = (req_addr[1:0] != 2'b00);
      default: misalign_in = 1'b0;
    endcase

    case (req_f3[1:0])
      2'b00:   mask_in = 4'b0001 << req_addr[1:0];
      2'b01:   mask_in = 4'b0011 << req_addr[1:0];
      default: mask_in = 4'b1111;
    endcase

    case (req_f3[1:0])
      2'b00:   wdata_in = {4{req_wdata[7:0]}};
      2'b01:   wdata_in = {2{req_wdata[15:0]}};
      default: wdata_in = req_wdata;
    endcase
  end

  always_comb begin
    lane = bus_rdata >> {lat_off, 3'b000};
    case (lat_f3)
      F3_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
      F3_LW:   load_data = lane;
      F3_LBU:  load_data = {24'd0, lane[7:0]};
      F3_LHU:  load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      to_cnt    <= '0;
      lat_off   <= 2'b00;
      lat_f3    <= 3'b000;
      req_ready <= 1'b1;
      bus_valid <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_mask  <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rd    <= 5'd0;
      rsp_data  <= 32'd0;
      rsp_cause <= CAUSE_OK;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_rd    <= req_rd;
            lat_off   <= req_addr[1:0];
            lat_f3    <= req_f3;
            to_cnt    <= '0;
            req_ready <= 1'b0;
            if (illegal_in || misalign_in) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= 32'd0;
              rsp_cause <= illegal_in ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            end else begin
              state     <= BUS;
              bus_valid <= 1'b1;
              bus_write <= is_store_in;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_wdata <= is_store_in ? wdata_in : 32'd0;
              bus_mask  <= mask_in;
            end
          end
        end

        BUS: begin
          if (bus_err || bus_ack ||
              (TIMEOUT_CYCLES != 0 && to_cnt == TO_LAST)) begin
            state     <= RESP;
            bus_valid <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_mask  <= 4'd0;
            rsp_valid <= 1'b1;
            if (bus_err || !bus_ack) begin
              rsp_cause <= CAUSE_BUS_FAULT;
              rsp_data  <= 32'd0;
            end else begin
              rsp_cause <= CAUSE_OK;
              rsp_data  <= bus_write ? 32'd0 : load_data;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rd    <= 5'd0;
            rsp_data  <= 32'd0;
            rsp_cause <= CAUSE_OK;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed self-checking bench for rv32i_lsu, built with a 4-cycle timeout.
module tb_rv32i_lsu;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_OPIMM = 5'b00100;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_mask;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_cause;

  int total = 0;
  int bad   = 0;

  rv32i_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_mask(bus_mask), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_data(rsp_data), .rsp_cause(rsp_cause)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd);
    req_op    = op;
    req_f3    = f3;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rdata, input logic err);
    bus_ack   = 1'b1;
    bus_err   = err;
    bus_rdata = rdata;
    step();
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_f3 = '0; req_addr = '0;
    req_wdata = '0; req_rd = '0; bus_ack = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    rsp_ready = 1'b0;
    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_mask",  32'(bus_mask),  32'd0);
    chk("rst_bus_addr",  bus_addr,       32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  rsp_data,       32'd0);
    chk("rst_rsp_cause", 32'(rsp_cause), 32'd0);
    reset = 1'b0;
    step();

    // LB from the top byte lane, sign extended
    issue(OP_LOAD, 3'b000, 32'h0000_1003, 32'hFFFF_FFFF, 5'd7);
    chk("lb_bus_valid", 32'(bus_valid), 32'd1);
    chk("lb_bus_write", 32'(bus_write), 32'd0);
    chk("lb_bus_addr",  bus_addr,       32'h0000_1000);
    chk("lb_bus_mask",  32'(bus_mask),  32'b1000);
    chk("lb_bus_wdata", bus_wdata,      32'd0);
    chk("lb_rsp_early", 32'(rsp_valid), 32'd0);
    chk("lb_req_ready", 32'(req_ready), 32'd0);
    ack(32'h80AA_BBCC, 1'b0);
    chk("lb_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lb_bus_drop",  32'(bus_valid), 32'd0);
    chk("lb_rsp_data",  rsp_data,       32'hFFFF_FF80);
    chk("lb_rsp_cause", 32'(rsp_cause), 32'd0);
    chk("lb_rsp_rd",    32'(rsp_rd),    32'd7);
    handshake("lb");

    issue(OP_LOAD, 3'b100, 32'h0000_1003, 32'd0, 5'd8);
    ack(32'h80AA_BBCC, 1'b0);
    chk("lbu_rsp_data", rsp_data, 32'h0000_0080);
    handshake("lbu");

    // LH from upper half, sign extended
    issue(OP_LOAD, 3'b001, 32'h0000_4002, 32'd0, 5'd9);
    chk("lh_bus_mask", 32'(bus_mask), 32'b1100);
    ack(32'h8001_1234, 1'b0);
    chk("lh_rsp_data", rsp_data, 32'hFFFF_8001);
    handshake("lh");

    // SH to upper half
    issue(OP_STORE, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd3);
    chk("sh_bus_write", 32'(bus_write), 32'd1);
    chk("sh_bus_mask",  32'(bus_mask),  32'b1100);
    chk("sh_bus_wdata", bus_wdata,      32'hABCD_ABCD);
    chk("sh_bus_addr",  bus_addr,       32'h0000_2000);
    ack(32'hDEAD_BEEF, 1'b0);
    chk("sh_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sh_rsp_data",  rsp_data,       32'd0);
    chk("sh_rsp_cause", 32'(rsp_cause), 32'd0);
    handshake("sh");

    // Decode faults respond the next cycle without a bus transaction
    issue(OP_LOAD, 3'b010, 32'h0000_3001, 32'd0, 5'd4);
    chk("lw_mis_bus_valid", 32'(bus_valid), 32'd0);
    chk("lw_mis_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lw_mis_cause",     32'(rsp_cause), 32'd1);
    chk("lw_mis_data",      rsp_data,       32'd0);
    handshake("lw_mis");

    issue(OP_OPIMM, 3'b000, 32'h0000_3000, 32'd0, 5'd5);
    chk("opimm_bus_valid", 32'(bus_valid), 32'd0);
    chk("opimm_cause",     32'(rsp_cause), 32'd2);
    handshake("opimm");

    issue(OP_LOAD, 3'b011, 32'h0000_3001, 32'd0, 5'd6);
    chk("f3_011_cause", 32'(rsp_cause), 32'd2);
    handshake("f3_011");

    issue(OP_STORE, 3'b011, 32'h0000_3000, 32'd0, 5'd6);
    chk("st_f3_011_cause", 32'(rsp_cause), 32'd2);
    handshake("st_f3_011");

    // SB with simultaneous ack+err, then a stalled consumer
    issue(OP_STORE, 3'b000, 32'h0000_5001, 32'h0000_00A5, 5'd10);
    chk("sb_bus_mask",  32'(bus_mask), 32'b0010);
    chk("sb_bus_wdata", bus_wdata,     32'hA5A5_A5A5);
    ack(32'h1111_1111, 1'b1);
    chk("err_cause", 32'(rsp_cause), 32'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_cause", 32'(rsp_cause), 32'd3);
      chk("stall_rsp_data",  rsp_data,       32'd0);
      chk("stall_rsp_rd",    32'(rsp_rd),    32'd10);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    handshake("stall");

    // Timeout with no ack: bus_valid high for exactly 4 cycles
    issue(OP_LOAD, 3'b010, 32'h0000_6000, 32'd0, 5'd11);
    for (int i = 0; i < 4; i++) begin
      chk("to_bus_valid", 32'(bus_valid), 32'd1);
      chk("to_rsp_idle",  32'(rsp_valid), 32'd0);
      step();
    end
    chk("to_bus_drop",  32'(bus_valid), 32'd0);
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_cause",     32'(rsp_cause), 32'd3);
    handshake("to");

    // Ack on the fourth cycle beats the timeout
    issue(OP_LOAD, 3'b010, 32'h0000_6000, 32'd0, 5'd12);
    step(); step(); step();
    chk("to_ack_still_bus", 32'(bus_valid), 32'd1);
    ack(32'h1122_3344, 1'b0);
    chk("to_ack_cause", 32'(rsp_cause), 32'd0);
    chk("to_ack_data",  rsp_data,       32'h1122_3344);
    handshake("to_ack");

    // Reset mid-transaction, then a late ack is ignored
    issue(OP_LOAD, 3'b010, 32'h0000_7000, 32'd0, 5'd13);
    chk("rm_bus_valid", 32'(bus_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rm_bus_drop",  32'(bus_valid), 32'd0);
    chk("rm_req_ready", 32'(req_ready), 32'd1);
    ack(32'hCAFE_F00D, 1'b0);
    chk("rm_late_ack_rsp", 32'(rsp_valid), 32'd0);
    chk("rm_late_ack_bus", 32'(bus_valid), 32'd0);
    step();
    chk("rm_still_idle", 32'(req_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
